pipe_hazard_ctrl: RTL

Parametrised pipeline control unit that turns per-source stall requests into a freeze mask over the pipeline stages, sequences exception/redirect flushes, and keeps per-cause stall-cycle statistics. It sits beside the datapath, in the same place as the current fixed 6-bit stall controller. It generalises that controller to N requesters with configurable stall depth, adds a registered flush/new-PC sequencer with a post-flush re-trigger guard, and adds saturating performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of stall requests, exception redirect and statistics outputs for pipe_hazard_ctrl.
// excp_pc is qualified by excp_req; there is no ready: a request is taken when sampled in RUN.
interface pipe_hazard_ctrl_if #(
  parameter int STAGES = 6,
  parameter int NREQ   = 2,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
);
  localparam int CW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       stall_req;
  logic                  excp_req;
  logic [PC_W-1:0]       excp_pc;
  logic                  clr_cnt;
  logic [STAGES-1:0]     stall;
  logic                  flush;
  logic [PC_W-1:0]       new_pc;
  logic [CW-1:0]         cause;
  logic                  cause_vld;
  logic [CNT_W-1:0]      cnt_total;
  logic [NREQ*CNT_W-1:0] cnt_cause;
  logic [1:0]            fsm_state;

  modport master (
    output stall_req, excp_req, excp_pc, clr_cnt,
    input  stall, flush, new_pc, cause, cause_vld, cnt_total, cnt_cause, fsm_state
  );

  modport slave (
    input  stall_req, excp_req, excp_pc, clr_cnt,
    output stall, flush, new_pc, cause, cause_vld, cnt_total, cnt_cause, fsm_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: stall-request to freeze-mask merge, flush/redirect sequencer
// with post-flush drain guard, and saturating per-cause stall statistics.
module pipe_hazard_ctrl #(
  parameter int               STAGES    = 6,
  parameter int               NREQ      = 2,
  parameter logic [4*NREQ-1:0] REQ_STAGE = {4'd3, 4'd2},
  parameter int               PC_W      = 32,
  parameter int               DRAIN_CYC = 3,
  parameter int               CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int CW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q;
  logic [DW-1:0]   drn_q;
  logic [PC_W-1:0] pc_q;
  logic            flush_q;

  logic              flush_o;
  logic [NREQ-1:0]   req_eff;
  logic [STAGES-1:0] stall_d;
  logic [CW-1:0]     win_d;
  logic [3:0]        win_stg;
  logic              found;

  logic [CNT_W-1:0] tot_q;
  logic [CNT_W-1:0] cc_q [NREQ];

  // pc_q is cleared on leaving FLUSH so new_pc reads zero outside the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drn_q   <= '0;
      pc_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.excp_req) begin
            state_q <= FLUSH;
            pc_q    <= bus.excp_pc;
            drn_q   <= DW'(DRAIN_CYC);
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= DRAIN;
          pc_q    <= '0;
          flush_q <= 1'b0;
        end
        DRAIN: begin
          drn_q <= drn_q - DW'(1);
          if (drn_q <= DW'(1)) state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o = flush_q & ~rst;

  // Largest REQ_STAGE wins; strict compare keeps the lowest index on ties.
  always_comb begin
    req_eff = bus.stall_req & {NREQ{~(rst | flush_o)}};
    stall_d = '0;
    win_d   = '0;
    win_stg = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_eff[i]) begin
        for (int s = 0; s < STAGES; s++) begin
          if (s <= int'(REQ_STAGE[4*i +: 4])) stall_d[s] = 1'b1;
        end
        if (!found || (REQ_STAGE[4*i +: 4] > win_stg)) begin
          found   = 1'b1;
          win_d   = CW'(i);
          win_stg = REQ_STAGE[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      tot_q <= '0;
      for (int i = 0; i < NREQ; i++) cc_q[i] <= '0;
    end else if (found) begin
      if (tot_q != '1) tot_q <= tot_q + CNT_W'(1);
      if (cc_q[win_d] != '1) cc_q[win_d] <= cc_q[win_d] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign bus.cnt_cause[g*CNT_W +: CNT_W] = cc_q[g];
  end

  assign bus.stall     = stall_d;
  assign bus.cause     = win_d;
  assign bus.cause_vld = found;
  assign bus.flush     = flush_o;
  assign bus.new_pc    = flush_o ? pc_q : '0;
  assign bus.cnt_total = tot_q;
  assign bus.fsm_state = state_q;
endmodule
